// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the I2S transceiver APB driver.
//   state_e     - APB master FSM states (IDLE, SETUP, ACCESS)
//   op_e        - operation selected in IDLE (OP_CTRL, OP_STAT, OP_TX, OP_RX)
//   FLAG_*      - bit positions inside the status flag nibble
//   FLAGS_RESET - flag shadow value held until the first status read
//   op_is_write - 1 for operations that drive pwrite
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_CTRL = 2'd0,
    OP_STAT = 2'd1,
    OP_TX   = 2'd2,
    OP_RX   = 2'd3
  } op_e;

  // Status nibble layout: {Tx_full, Tx_empty, Rx_full, Rx_empty}
  localparam int FLAG_RX_EMPTY = 0;
  localparam int FLAG_RX_FULL  = 1;
  localparam int FLAG_TX_EMPTY = 2;
  localparam int FLAG_TX_FULL  = 3;

  // Tx_full asserted so nothing is pushed before the first status read.
  localparam logic [3:0] FLAGS_RESET = 4'b1010;

  function automatic logic op_is_write(input op_e op);
    return (op == OP_CTRL) || (op == OP_TX);
  endfunction

endpackage

// File: rtl/poll_timer.sv
// poll_timer: down-counter that paces status re-polls while the driver idles.
//   pclk      in  clock
//   preset    in  async active-low reset (count -> 0)
//   i_load    in  reload the counter with i_load_val
//   i_load_val in  reload value (idle cycles - 1)
//   i_enable  in  count one idle cycle
//   o_expire  out terminal count reached while enabled
module poll_timer
#(
  parameter int WIDTH = 2
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_enable,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // Expire is combinational so the re-poll can be granted in the same
  // IDLE cycle the count runs out.
  assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/i2s_apb_driver.sv
// i2s_apb_driver: APB master that services an I2S transceiver's register map.
// Forwards control words and Tx samples as APB writes, drains the Rx FIFO
// with APB reads, and keeps a shadow of the transceiver status flags that is
// refreshed after every FIFO access and periodically while idle.
//   pclk, preset                  clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata, prdata, pready   APB master port
//   cfg_valid/cfg_data/cfg_ready  control word handshake
//   tx_valid/tx_data/tx_ready     Tx sample handshake
//   rx_valid/rx_data/rx_ready     Rx sample handshake
//   busy                          APB transfer in progress
//
// state  | meaning
// IDLE   | no transfer; pick next operation by priority
// SETUP  | psel=1, penable=0, address/data registered
// ACCESS | psel=1, penable=1, wait for pready
module i2s_apb_driver
  import ctrl_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR = 32'h0,
  parameter logic [31:0] TX_ADDR   = 32'h4,
  parameter logic [31:0] RX_ADDR   = 32'h8,
  parameter logic [31:0] STAT_ADDR = 32'hC,
  parameter int          POLL_GAP  = 4
) (
  input  logic        pclk,
  input  logic        preset,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  input  logic        rx_ready,
  output logic        busy
);

  localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  // The grant itself happens in the last counted IDLE cycle, hence -1.
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP == 0) ? '0 : GAP_W'(POLL_GAP - 1);

  state_e      r_state;
  op_e         r_op;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_cfg_ready;
  logic        r_tx_ready;
  logic        r_rx_valid;
  logic [31:0] r_rx_data;
  logic [3:0]  r_flags;
  logic        r_stale;

  logic        w_is_idle;
  logic        w_cfg_pend;
  logic        w_tx_pend;
  logic        w_rx_pend;
  logic        w_poll_en;
  logic        w_poll_expire;
  logic        w_stat_due;
  logic        w_grant;
  op_e         w_op;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_unused_flags;

  always_comb begin
    w_is_idle = (r_state == IDLE);
    // A source still shows valid during its ready cycle; that word is
    // already consumed and must not be sent twice.
    w_cfg_pend = cfg_valid && !r_cfg_ready;
    w_tx_pend  = tx_valid && !r_tx_ready && !r_flags[FLAG_TX_FULL];
    w_rx_pend  = !r_flags[FLAG_RX_EMPTY] && (!r_rx_valid || rx_ready);
    w_poll_en  = w_is_idle && !r_stale && !w_cfg_pend && !w_tx_pend && !w_rx_pend;
    w_stat_due = r_stale || w_poll_expire;
    w_grant    = w_is_idle && (w_cfg_pend || w_stat_due || w_tx_pend || w_rx_pend);

    w_op = OP_RX;
    if (w_cfg_pend) begin
      w_op = OP_CTRL;
    end else if (w_stat_due) begin
      w_op = OP_STAT;
    end else if (w_tx_pend) begin
      w_op = OP_TX;
    end

    w_addr  = STAT_ADDR;
    w_wdata = '0;
    case (w_op)
      OP_CTRL: begin
        w_addr  = CTRL_ADDR;
        w_wdata = cfg_data;
      end
      OP_TX: begin
        w_addr  = TX_ADDR;
        w_wdata = tx_data;
      end
      OP_RX:   w_addr = RX_ADDR;
      default: w_addr = STAT_ADDR;
    endcase
  end

  poll_timer #(
    .WIDTH (GAP_W)
  ) u_poll_timer (
    .pclk       (pclk),
    .preset     (preset),
    .i_load     (w_grant),
    .i_load_val (GAP_LOAD),
    .i_enable   (w_poll_en),
    .o_expire   (w_poll_expire)
  );

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= IDLE;
      r_op        <= OP_STAT;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_cfg_ready <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_flags     <= FLAGS_RESET;
      r_stale     <= 1'b1;
    end else begin
      r_cfg_ready <= 1'b0;
      r_tx_ready  <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_poll_expire) r_stale <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= SETUP;
            r_op      <= w_op;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= op_is_write(w_op);
            r_paddr   <= w_addr;
            r_pwdata  <= w_wdata;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            case (r_op)
              OP_CTRL: r_cfg_ready <= 1'b1;
              OP_STAT: begin
                r_flags <= prdata[3:0];
                r_stale <= 1'b0;
              end
              OP_TX: begin
                r_tx_ready <= 1'b1;
                r_stale    <= 1'b1;
              end
              OP_RX: begin
                // New data wins over a same-cycle consume, so rx_valid stays 1.
                r_rx_data  <= prdata;
                r_rx_valid <= 1'b1;
                r_stale    <= 1'b1;
              end
              default: r_stale <= 1'b1;
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Rx_full and Tx_empty are shadowed with the rest of the nibble but do not
  // gate any operation.
  assign w_unused_flags = r_flags[FLAG_RX_FULL] ^ r_flags[FLAG_TX_EMPTY];

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign cfg_ready = r_cfg_ready;
  assign tx_ready  = r_tx_ready;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_i2s_apb_driver.sv
`timescale 1ns/1ps
module tb_i2s_apb_driver;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready = 1'b0;
  logic        busy;

  i2s_apb_driver dut (
    .pclk      (pclk),
    .preset    (preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        rx_ready;
    logic [31:0] prdata;
    logic [31:0] exp_addr;
    logic        exp_write;
    logic [31:0] exp_wdata;
    int          exp_gap;
    logic        exp_cfg_ready;
    logic        exp_tx_ready;
    logic        exp_rx_valid;
    logic [31:0] exp_rx_data;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cfg_rdy = 0;
  int   n_tx_rdy = 0;
  int   gap;
  int   base_cfg, base_tx;

  always @(negedge pclk) begin
    if (cfg_ready) n_cfg_rdy++;
    if (tx_ready)  n_tx_rdy++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge inside a SETUP cycle; gap = IDLE negedges seen.
  task automatic wait_setup(output int g);
    g = 0;
    while (!(psel === 1'b1 && penable === 1'b0) && g < 50) begin
      g++;
      @(negedge pclk);
    end
    if (!(psel === 1'b1 && penable === 1'b0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL setup_timeout: no SETUP within %0d cycles", g);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cfg_v cfg_d     tx_v tx_d        rx_r prdata       addr    wr wdata       gap cfg_r tx_r rx_v rx_d
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h4,      32'hC,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 32'h1234,  1'b0, 32'h0,      32'h4,  1'b1, 32'h1234,  1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h8,      32'hC,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'hBEEF,   32'h8,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b1, 32'hBEEF};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h8,      32'hC,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b1, 32'hBEEF};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h8,      32'hC,  1'b0, 32'h0,     4, 1'b0, 1'b0, 1'b1, 32'hBEEF};
    vecs[6]  = '{1'b1, 32'hA5,  1'b1, 32'h5555,  1'b0, 32'h0,      32'h0,  1'b1, 32'hA5,    1, 1'b1, 1'b0, 1'b1, 32'hBEEF};
    vecs[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b1, 32'hCAFE,   32'h8,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b1, 32'hCAFE};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b1, 32'h9,      32'hC,  1'b0, 32'h0,     1, 1'b0, 1'b0, 1'b0, 32'hCAFE};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h9,      32'hC,  1'b0, 32'h0,     4, 1'b0, 1'b0, 1'b0, 32'hCAFE};
    vecs[10] = '{1'b0, 32'h0,   1'b1, 32'h77,    1'b0, 32'h4,      32'hC,  1'b0, 32'h0,     4, 1'b0, 1'b0, 1'b0, 32'hCAFE};
    vecs[11] = '{1'b0, 32'h0,   1'b1, 32'h77,    1'b0, 32'h0,      32'h4,  1'b1, 32'h77,    1, 1'b0, 1'b1, 1'b0, 32'hCAFE};

    #2 preset = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_psel",      32'(psel),      32'h0);
    chk("rst_penable",   32'(penable),   32'h0);
    chk("rst_pwrite",    32'(pwrite),    32'h0);
    chk("rst_paddr",     paddr,          32'h0);
    chk("rst_pwdata",    pwdata,         32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h0);
    chk("rst_tx_ready",  32'(tx_ready),  32'h0);
    chk("rst_rx_valid",  32'(rx_valid),  32'h0);
    chk("rst_rx_data",   rx_data,        32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    preset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cfg_valid = vecs[i].cfg_valid;
      cfg_data  = vecs[i].cfg_data;
      tx_valid  = vecs[i].tx_valid;
      tx_data   = vecs[i].tx_data;
      rx_ready  = vecs[i].rx_ready;
      prdata    = vecs[i].prdata;
      wait_setup(gap);
      chk($sformatf("v%0d_gap", i),    32'(gap),    32'(vecs[i].exp_gap));
      chk($sformatf("v%0d_paddr", i),  paddr,       vecs[i].exp_addr);
      chk($sformatf("v%0d_pwrite", i), 32'(pwrite), 32'(vecs[i].exp_write));
      chk($sformatf("v%0d_busy", i),   32'(busy),   32'h1);
      if (vecs[i].exp_write) chk($sformatf("v%0d_pwdata", i), pwdata, vecs[i].exp_wdata);
      @(negedge pclk);
      chk($sformatf("v%0d_penable", i),    32'(penable), 32'h1);
      chk($sformatf("v%0d_paddr_hold", i), paddr,        vecs[i].exp_addr);
      @(negedge pclk);
      chk($sformatf("v%0d_psel_done", i), 32'(psel),      32'h0);
      chk($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_cfg_ready));
      chk($sformatf("v%0d_tx_ready", i),  32'(tx_ready),  32'(vecs[i].exp_tx_ready));
      chk($sformatf("v%0d_rx_valid", i),  32'(rx_valid),  32'(vecs[i].exp_rx_valid));
      chk($sformatf("v%0d_rx_data", i),   rx_data,        vecs[i].exp_rx_data);
    end

    // CTRL beats a pending TX; cfg_valid held through its ready cycle must not resend.
    cfg_valid = 1'b1; cfg_data = 32'hA5; tx_valid = 1'b1; tx_data = 32'h1234; prdata = 32'h4;
    @(posedge pclk); #1;
    base_cfg = n_cfg_rdy; base_tx = n_tx_rdy;
    @(negedge pclk);
    wait_setup(gap);
    chk("h1_ctrl_paddr",  paddr,        32'h0);
    chk("h1_ctrl_pwdata", pwdata,       32'hA5);
    chk("h1_ctrl_pwrite", 32'(pwrite),  32'h1);
    @(negedge pclk);
    @(negedge pclk);
    chk("h1_cfg_ready", 32'(cfg_ready), 32'h1);
    @(posedge pclk); #1;
    cfg_valid = 1'b0;
    @(negedge pclk);
    wait_setup(gap);
    chk("h1_stat_paddr", paddr, 32'hC);
    @(negedge pclk);
    @(negedge pclk);
    wait_setup(gap);
    chk("h1_tx_paddr",  paddr,  32'h4);
    chk("h1_tx_pwdata", pwdata, 32'h1234);
    @(negedge pclk);
    @(negedge pclk);
    chk("h1_tx_ready", 32'(tx_ready), 32'h1);
    @(posedge pclk); #1;
    tx_valid = 1'b0;
    chk("h1_cfg_pulses", 32'(n_cfg_rdy - base_cfg), 32'h1);
    chk("h1_tx_pulses",  32'(n_tx_rdy - base_tx),   32'h1);

    // Wait states: TX access stalled three cycles with pready=0.
    tx_valid = 1'b1; tx_data = 32'hABCD;
    @(negedge pclk);
    wait_setup(gap);
    chk("h2_stat_paddr", paddr, 32'hC);
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b0;
    wait_setup(gap);
    chk("h2_tx_paddr", paddr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk($sformatf("h2_w%0d_psel", k),     32'(psel),     32'h1);
      chk($sformatf("h2_w%0d_penable", k),  32'(penable),  32'h1);
      chk($sformatf("h2_w%0d_paddr", k),    paddr,         32'h4);
      chk($sformatf("h2_w%0d_pwdata", k),   pwdata,        32'hABCD);
      chk($sformatf("h2_w%0d_pwrite", k),   32'(pwrite),   32'h1);
      chk($sformatf("h2_w%0d_busy", k),     32'(busy),     32'h1);
      chk($sformatf("h2_w%0d_tx_ready", k), 32'(tx_ready), 32'h0);
    end
    pready = 1'b1;
    @(negedge pclk);
    chk("h2_tx_ready", 32'(tx_ready), 32'h1);
    chk("h2_psel",     32'(psel),     32'h0);
    chk("h2_busy",     32'(busy),     32'h0);
    @(posedge pclk); #1;
    tx_valid = 1'b0;

    // Reset asserted mid-ACCESS abandons the TX without a handshake.
    tx_valid = 1'b1; tx_data = 32'h99; prdata = 32'h4;
    @(negedge pclk);
    wait_setup(gap);
    chk("h3_stat_paddr", paddr, 32'hC);
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b0;
    wait_setup(gap);
    chk("h3_tx_paddr", paddr, 32'h4);
    @(negedge pclk);
    base_tx = n_tx_rdy;
    preset = 1'b0;
    #1;
    chk("h3_rst_psel",     32'(psel),     32'h0);
    chk("h3_rst_penable",  32'(penable),  32'h0);
    chk("h3_rst_busy",     32'(busy),     32'h0);
    chk("h3_rst_tx_ready", 32'(tx_ready), 32'h0);
    chk("h3_rst_paddr",    paddr,         32'h0);
    tx_valid = 1'b0; pready = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    wait_setup(gap);
    chk("h3_first_gap",   32'(gap),    32'h1);
    chk("h3_first_paddr", paddr,       32'hC);
    chk("h3_first_pwrite", 32'(pwrite), 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    chk("h3_first_done", 32'(psel), 32'h0);
    chk("h3_no_tx_pulse", 32'(n_tx_rdy - base_tx), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
